// File: rtl/calc_display_scan_if.sv
// Segment-bus bundle between the calculator core and the display scanner.
// The master side supplies the digit patterns, status and enable; the
// scanner (slave) returns the multiplexed segment bus and anode selects.
interface calc_display_scan_if;
    logic [7:0][6:0] displays;   // active-low segment patterns, displays[k] is digit k
    logic [1:0]      status;     // bit 1 = error, makes the display blink
    logic            enable;     // 0 blanks every digit, scanning continues
    logic [6:0]      seg;        // active-low segment bus
    logic [7:0]      an;         // active-low anode selects

    modport master (
        output displays,
        output status,
        output enable,
        input  seg,
        input  an
    );

    modport slave (
        input  displays,
        input  status,
        input  enable,
        output seg,
        output an
    );
endinterface

// File: rtl/calc_display_scan.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// A full frame of digit patterns and the status word are latched together at
// each frame boundary, so a frame never mixes old and new digits. While the
// latched error bit is set, the display blinks with a half-period of
// BLINK_FRAMES complete scan frames.
module calc_display_scan #(
    parameter int REFRESH_DIV  = 4,   // cycles each digit stays lit, >= 2
    parameter int BLINK_FRAMES = 2    // frames per blink half-period, >= 1
) (
    input  logic              clock,
    input  logic              reset,  // asynchronous, active-low
    calc_display_scan_if.slave bus
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Scan counters
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [FRM_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic             blink_phase_reg, blink_phase_next;

    // Frame buffer and latched status
    logic [7:0][6:0]  shadow_reg;
    logic [1:0]       status_sh_reg;

    // Registered outputs
    logic [6:0]       seg_reg, seg_next;
    logic [7:0]       an_reg, an_next;

    // Decode helpers
    logic             tick;
    logic             frame_end;
    logic             off;
    logic [7:0]       an_dec;

    // Only the error bit of the latched status affects the display.
    logic             unused_status;
    assign unused_status = status_sh_reg[0];

    assign tick      = (div_cnt_reg == DIV_LAST);
    assign frame_end = tick && (idx_reg == 3'd7);
    assign off       = !bus.enable || (status_sh_reg[1] && blink_phase_reg);

    // Active-low one-hot anode decode of the current digit index.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_an_dec
            assign an_dec[gi] = (idx_reg != 3'(gi));
        end
    endgenerate

    // Next-state logic for prescaler, digit index, frame counter and blink phase.
    always_comb begin
        div_cnt_next     = div_cnt_reg + 1'b1;
        idx_next         = idx_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;

        if (tick) begin
            div_cnt_next = '0;
            idx_next     = idx_reg + 3'd1;
        end

        if (frame_end) begin
            if (frame_cnt_reg == FRM_LAST) begin
                frame_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + 1'b1;
            end
        end
    end

    // Output selection: the digit shown is the one indexed before this edge,
    // so the anodes follow idx by exactly one clock.
    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        if (!off) begin
            an_next  = an_dec;
            seg_next = shadow_reg[idx_reg];
        end
    end

    // Scan counter state; runs regardless of enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt_reg     <= '0;
            idx_reg         <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            div_cnt_reg     <= div_cnt_next;
            idx_reg         <= idx_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
        end
    end

    // Frame-atomic capture of digit patterns and status at the frame boundary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_reg    <= {8{SEG_BLANK}};
            status_sh_reg <= '0;
        end else if (frame_end) begin
            shadow_reg    <= bus.displays;
            status_sh_reg <= bus.status;
        end
    end

    // Output registers; blank until the first digit is scanned after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_reg  <= AN_OFF;
            seg_reg <= SEG_BLANK;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign bus.seg = seg_reg;
    assign bus.an  = an_reg;

endmodule

// File: tb/tb_calc_display_scan.sv
// Bench for calc_display_scan: a frame-level reference model predicts an/seg
// from the edge count since reset, the frames captured at each boundary and
// the blink half-period arithmetic; a negedge process compares every cycle.
module tb_calc_display_scan;

    localparam int R     = 4;
    localparam int BF    = 2;
    localparam int FRAME = 8 * R;

    logic clock;
    logic reset;

    calc_display_scan_if bus();

    calc_display_scan #(
        .REFRESH_DIV (R),
        .BLINK_FRAMES(BF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit chk_on     = 0;

    // Reference model state
    int         t = 0;                 // rising edges since reset release
    logic [6:0] cap_disp [8];
    logic [1:0] cap_stat = 2'b00;
    logic [7:0] exp_an   = 8'hFF;
    logic [6:0] exp_seg  = 7'h7F;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: output at edge t shows digit ((t-1)/R)%8 of frame (t-1)/FRAME,
    // using the patterns captured at the previous boundary (edge multiple of FRAME).
    always @(posedge clock or negedge reset) begin
        int pos, idx, f, phase;
        bit off;
        if (!reset) begin
            t = 0;
            for (int k = 0; k < 8; k++) cap_disp[k] = 7'h7F;
            cap_stat = 2'b00;
            exp_an   = 8'hFF;
            exp_seg  = 7'h7F;
        end else begin
            t     = t + 1;
            pos   = t - 1;
            idx   = (pos / R) % 8;
            f     = pos / FRAME;
            phase = (f / BF) % 2;
            off   = !bus.enable || (cap_stat[1] && phase == 1);
            if (off) begin
                exp_an  = 8'hFF;
                exp_seg = 7'h7F;
            end else begin
                exp_an  = ~(8'd1 << idx);
                exp_seg = cap_disp[idx];
            end
            if (t % FRAME == 0) begin
                for (int k = 0; k < 8; k++) cap_disp[k] = bus.displays[k];
                cap_stat = bus.status;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_on) begin
            vectors++;
            if (bus.an !== exp_an) begin
                miscompares++;
                $display("FAIL model_an t=%0d: got %h expected %h", t, bus.an, exp_an);
            end
            vectors++;
            if (bus.seg !== exp_seg) begin
                miscompares++;
                $display("FAIL model_seg t=%0d: got %h expected %h", t, bus.seg, exp_seg);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, got, want);
        end else begin
            $display("ok   %s t=%0d: %h", name, t, got);
        end
    endtask

    // Advance to 1 time unit after model edge n (bounded).
    task automatic goto(input int n);
        int guard = 0;
        while (t < n && guard < 5000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        vectors++;
        if (t != n) begin
            miscompares++;
            $display("FAIL sync: reached edge %0d expected %0d", t, n);
        end
    endtask

    task automatic both(input string name, input logic [7:0] an_w, input logic [6:0] seg_w);
        chk({name, "_an"}, bus.an, an_w);
        chk({name, "_seg"}, {1'b0, bus.seg}, {1'b0, seg_w});
    endtask

    initial begin
        for (int k = 0; k < 8; k++) bus.displays[k] = 7'h40 | 7'(k);
        bus.status = 2'b00;
        bus.enable = 1'b1;
        reset      = 1'b1;

        // Asynchronous reset, asserted between edges
        #1 reset = 1'b0;
        #1;
        both("async_reset", 8'hFF, 7'h7F);
        chk_on = 1;
        repeat (3) @(posedge clock);
        #1;
        both("reset_hold", 8'hFF, 7'h7F);
        reset = 1'b1;

        // Basic scan: blank first frame, then the captured patterns
        goto(1);   both("scan_first", 8'hFE, 7'h7F);
        goto(5);   both("scan_d1", 8'hFD, 7'h7F);
        goto(32);  both("scan_f0_end", 8'h7F, 7'h7F);
        goto(33);  both("scan_f1_d0", 8'hFE, 7'h40);
        goto(64);  both("scan_f1_d7", 8'h7F, 7'h47);

        // Frame-atomic capture: change digit 5 while digit 3 is lit
        goto(78);  chk("atomic_pre_an", bus.an, 8'hF7);
        bus.displays[5] = 7'h12;
        goto(86);  both("atomic_old", 8'hDF, 7'h45);
        goto(118); both("atomic_new", 8'hDF, 7'h12);
        bus.displays[5] = 7'h45;

        // Blink: error raised mid-frame, takes effect after the boundary
        goto(170); bus.status = 2'b10;
        goto(192); chk("blink_not_yet", bus.an, 8'h7F);
        goto(193); both("blink_off_start", 8'hFF, 7'h7F);
        goto(256); both("blink_off_end", 8'hFF, 7'h7F);
        goto(257); both("blink_on_start", 8'hFE, 7'h40);
        goto(320); both("blink_on_end", 8'h7F, 7'h47);
        goto(330); bus.status = 2'b00;
        goto(340); chk("blink_clear_pending", bus.an, 8'hFF);
        goto(353); both("blink_cleared", 8'hFE, 7'h40);

        // Enable dropped for 6 cycles during digit 2
        goto(393); chk("en_pre", bus.an, 8'hFB);
        bus.enable = 1'b0;
        goto(394); both("en_off_first", 8'hFF, 7'h7F);
        goto(399); chk("en_off_last", bus.an, 8'hFF);
        bus.enable = 1'b1;
        goto(400); both("en_resume", 8'hF7, 7'h43);

        // Reset mid-operation while digit 6 is lit
        goto(442); chk("midrst_pre", bus.an, 8'hBF);
        #2 reset = 1'b0;
        #1;
        both("midrst_immediate", 8'hFF, 7'h7F);
        repeat (3) @(posedge clock);
        #1;
        both("midrst_hold", 8'hFF, 7'h7F);
        #1 reset = 1'b1;
        goto(1);   both("midrst_restart", 8'hFE, 7'h7F);
        goto(32);  both("midrst_blank_frame", 8'h7F, 7'h7F);
        goto(33);  both("midrst_recapture", 8'hFE, 7'h40);

        // Randomized phase: patterns, status and enable change at random times
        for (int c = 0; c < 1500; c++) begin
            @(posedge clock);
            #1;
            if ($urandom_range(0, 7) == 0)
                bus.displays[$urandom_range(0, 7)] = 7'($urandom);
            if ($urandom_range(0, 63) == 0)
                bus.status = 2'($urandom);
            bus.enable = ($urandom_range(0, 15) != 0);
        end

        @(negedge clock);
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_display_scan.md
# calc_display_scan

Downstream stage of `calc_top`. It takes the eight per-digit seven-segment patterns and the 2-bit status, and drives a physical 8-digit common-anode display through a time-multiplexed segment bus. The block latches a full frame of digits at each frame boundary, so the display never shows a mix of old and new digits. While `status[1]` is set, the whole display blinks.

## Interface
- `REFRESH_DIV`, default 4: clock cycles each digit stays active. Must be ≥ 2.
- `BLINK_FRAMES`, default 2: complete scan frames per blink half-period. Must be ≥ 1.
- `clock` — input, 1 bit: single clock; all state updates on its rising edge.
- `reset` — input, 1 bit: asynchronous, active-low.
- `enable` — input, 1 bit: 0 turns all digits off; the scan counters keep running.
- `displays` — input, [6:0] × [7:0]: segment patterns from `calc_top`, active-low. `displays[k]` is digit k.
- `status` — input, 2 bits: status from `calc_top`. Bit 1 set means error, which makes the display blink.
- `seg` — output, 7 bits: segment bus, active-low, registered.
- `an` — output, 8 bits: digit anode selects, active-low, one-hot or all-off, registered.

## Operation
- **State registers:**
  - `div_cnt`: prescaler.
  - `idx`: current digit, 3 bits.
  - `shadow[7:0]`: 7-bit frame buffer.
  - `status_sh`: latched status.
  - `frame_cnt`: frame counter, 0..BLINK_FRAMES-1.
  - `blink_phase`: 1 bit.
- **Prescaler:**
  - `tick` = (`div_cnt` == REFRESH_DIV-1).
  - On `tick`, `div_cnt` ← 0 and `idx` ← `idx`+1, wrapping 7→0.
  - Otherwise `div_cnt` increments.
- **Frame boundary** (`tick` while `idx` == 7):
  - `shadow` ← `displays` and `status_sh` ← `status`.
  - If `frame_cnt` == BLINK_FRAMES-1: `frame_cnt` ← 0 and `blink_phase` toggles. Otherwise `frame_cnt` increments.
- **Input capture:** `displays` and `status` are sampled only at a frame boundary. Changes at any other time have no effect until the next boundary.
- **Blanking condition:** `off` = !`enable` OR (`status_sh[1]` AND `blink_phase`).
- **Output registers:**
  - If `off`: `an` ← 8'hFF and `seg` ← 7'h7F.
  - Otherwise: `an` ← ~(8'b1 << `idx`) and `seg` ← `shadow[idx]`.
- **Digit order:** `idx` 0 drives `an[0]` with `displays[0]`, up to `idx` 7.
- **First frame after reset:** `shadow` holds its reset value, so every digit shows blank patterns while its anode is still driven.

## Timing
- **Reset** (`reset` = 0, acts immediately with no clock edge needed):
  - `an` = 8'hFF, `seg` = 7'h7F.
  - `div_cnt` = 0, `idx` = 0, `frame_cnt` = 0, `blink_phase` = 0.
  - `shadow[*]` = 7'h7F, `status_sh` = 0.
- **Reset mid-scan:** returns every register to the values above. Scanning restarts from digit 0 after release, and the shadow contents are lost.
- **Latency:** `an`/`seg` reflect `idx` one clock after `idx` changes.
  - First rising edge after reset release: `an` = 8'hFE.
  - Each digit is active for exactly REFRESH_DIV cycles.
  - One frame = 8·REFRESH_DIV cycles.
- **Capture point:** the captured `shadow` first appears on the outputs at the edge after the capture edge, on digit 0.
- **Enable:**
  - Deasserting `enable` blanks the outputs at the next edge.
  - Reasserting resumes at the current `idx`; the scan does not restart.
  - Counters, shadow capture and blink phase are unaffected by `enable`.
- **Blink:**
  - The blink half-period is BLINK_FRAMES frames, aligned to frame boundaries.
  - `status[1]` raised mid-frame takes effect only after the next boundary.
  - Clearing `status[1]` stops blinking after the next boundary.
- **Simultaneous events:** a frame boundary coinciding with a `displays` change captures the value present at that edge.

## Test plan
All scenarios use REFRESH_DIV = 4 and BLINK_FRAMES = 2.
- **Asynchronous reset:** assert `reset` = 0 between clock edges → `an` = 8'hFF and `seg` = 7'h7F immediately, and both hold with the clock running.
- **Basic scan:** release reset with `displays[k]` = 7'h40|k and `enable` = 1.
  - Cycles 1–32: `an` walks FE, FD, FB, F7, EF, DF, BF, 7F, 4 cycles each, with `seg` = 7'h7F.
  - Cycles 33–64: same `an` sequence, with `seg` = 7'h40..7'h47.
- **Frame-atomic capture:** change `displays[5]` to 7'h12 while `an` = 8'hF7 → `seg` on digit 5 keeps its old value for the rest of the frame and shows 7'h12 in the next frame.
- **Blink:** set `status[1]` = 1 mid-frame.
  - After the next boundary, the display blanks completely (`an` = 8'hFF) for 2 frames (64 cycles), then shows for 2 frames, repeating.
  - Clearing `status[1]` gives continuous display from the boundary after the clear.
- **Enable:** drop `enable` for 6 cycles during digit 2 → `an` = 8'hFF for those 6 cycles. On re-enable, `an` continues at the digit the free-running counter has reached (8'hF7), with no restart to 8'hFE.
- **Reset mid-operation:** pulse `reset` low while `an` = 8'hBF → outputs are blank during reset. After release, `an` = 8'hFE and `seg` = 7'h7F for the first frame, because the shadow was cleared.
